// File: rtl/vd_pkg.sv
// rtl/vd_pkg.sv - shared state encoding, mode codes and address constants for the vector divider
//
// Contents:
//   vd_state_e        sequencer states
//   MODE_*            arithmetic mode codes (bit1 = signed, bit0 = remainder)
//   PAIR_STRIDE_LOG2  log2 of words per operand pair in RAM
//   X_OFFSET/Y_OFFSET word offsets of X and Y inside a pair

package vd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_X,
    ST_RD_Y,
    ST_CAP_Y,
    ST_DIV,
    ST_WR,
    ST_DONE
  } vd_state_e;

  localparam logic [1:0] MODE_UQ = 2'b00;
  localparam logic [1:0] MODE_UR = 2'b01;
  localparam logic [1:0] MODE_SQ = 2'b10;
  localparam logic [1:0] MODE_SR = 2'b11;

  // Operands are stored as interleaved X,Y pairs: two words per element.
  localparam int PAIR_STRIDE_LOG2 = 1;
  localparam int X_OFFSET         = 0;
  localparam int Y_OFFSET         = 1;

endpackage

// File: rtl/div_core.sv
// rtl/div_core.sv - NBITS iterative restoring divider with zero-divisor and signed-overflow short-circuit
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   start                 one-cycle load pulse; dividend/divisor/signed_en sampled here
//   signed_en             treat operands as two's complement, truncate toward zero
//   dividend, divisor     operands
//   quotient, remainder   results, valid from done until the next start
//   done                  one-cycle pulse when results are ready
//   dz                    divisor was zero on the last start (held until next start)

module div_core #(
  parameter int NBITS = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_en,
  input  logic [NBITS-1:0] dividend,
  input  logic [NBITS-1:0] divisor,
  output logic [NBITS-1:0] quotient,
  output logic [NBITS-1:0] remainder,
  output logic             done,
  output logic             dz
);

  localparam logic [NBITS-1:0] MIN_VAL = {1'b1, {(NBITS-1){1'b0}}};
  localparam int               CNT_W   = $clog2(NBITS + 1);

  logic [NBITS-1:0] q_q, r_q, d_q;
  logic             neg_quo_q, neg_rem_q, busy_q;
  logic [CNT_W-1:0] cnt_q;

  logic             a_neg, b_neg;
  logic [NBITS-1:0] a_mag, b_mag;
  logic [2*NBITS-1:0] first_step, next_step;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and keep the subtraction only if it did not borrow.
  // Returns {remainder, quotient}.
  function automatic logic [2*NBITS-1:0] div_step(input logic [NBITS-1:0] rem,
                                                  input logic [NBITS-1:0] q,
                                                  input logic [NBITS-1:0] d);
    logic [NBITS:0] shifted;
    logic [NBITS:0] diff;
    shifted = {rem, q[NBITS-1]};
    diff    = shifted - {1'b0, d};
    if (diff[NBITS]) begin
      return {shifted[NBITS-1:0], q << 1};
    end
    return {diff[NBITS-1:0], (q << 1) | NBITS'(1)};
  endfunction

  always_comb begin
    a_neg = signed_en & dividend[NBITS-1];
    b_neg = signed_en & divisor[NBITS-1];
    a_mag = a_neg ? -dividend : dividend;
    b_mag = b_neg ? -divisor : divisor;
  end

  // The first quotient bit is produced on the load edge so that a normal
  // division finishes exactly NBITS edges after start.
  assign first_step = div_step('0, a_mag, b_mag);
  assign next_step  = div_step(r_q, q_q, d_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      q_q       <= '0;
      r_q       <= '0;
      d_q       <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      done      <= 1'b0;
      dz        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        d_q       <= b_mag;
        neg_quo_q <= 1'b0;
        neg_rem_q <= 1'b0;
        busy_q    <= 1'b0;
        cnt_q     <= '0;
        if (divisor == '0) begin
          q_q  <= '1;
          r_q  <= dividend;
          dz   <= 1'b1;
          done <= 1'b1;
        end else if (signed_en && dividend == MIN_VAL && divisor == '1) begin
          // MIN / -1 does not fit; saturate to MIN with zero remainder.
          q_q  <= MIN_VAL;
          r_q  <= '0;
          dz   <= 1'b0;
          done <= 1'b1;
        end else begin
          {r_q, q_q} <= first_step;
          neg_quo_q  <= a_neg ^ b_neg;
          neg_rem_q  <= a_neg;
          dz         <= 1'b0;
          cnt_q      <= CNT_W'(NBITS - 1);
          busy_q     <= (NBITS > 1);
          done       <= (NBITS == 1);
        end
      end else if (busy_q) begin
        {r_q, q_q} <= next_step;
        cnt_q      <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          busy_q <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

  assign quotient  = neg_quo_q ? -q_q : q_q;
  assign remainder = neg_rem_q ? -r_q : r_q;

endmodule

// File: rtl/vector_divider_mc.sv
// rtl/vector_divider_mc.sv - RAM-resident vector divider: reads X/Y pairs, writes quotient or remainder
//
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   Addr, Wdata, Wenable, Rdata  single-port RAM, synchronous read (Rdata one cycle after Addr)
//   Ndata, src_base, dst_base    pair count and base addresses, sampled on accepted start
//   mode                         00 uq, 01 ur, 10 sq, 11 sr, sampled on accepted start
//   startvd                      start request, honoured only in IDLE
//   busyvd, donevd               run status and one-cycle completion pulse
//   dz_err, dz_count             sticky zero-divisor flag and saturating count for the run

module vector_divider_mc
  import vd_pkg::*;
#(
  parameter int RAM_SIZE = 10,
  parameter int NBITS    = 32,
  parameter int CNT_W    = 10
) (
  input  logic                clock,
  input  logic                reset,
  output logic [RAM_SIZE-1:0] Addr,
  output logic [NBITS-1:0]    Wdata,
  input  logic [NBITS-1:0]    Rdata,
  output logic                Wenable,
  input  logic [RAM_SIZE-1:0] Ndata,
  input  logic [RAM_SIZE-1:0] src_base,
  input  logic [RAM_SIZE-1:0] dst_base,
  input  logic [1:0]          mode,
  input  logic                startvd,
  output logic                busyvd,
  output logic                donevd,
  output logic                dz_err,
  output logic [CNT_W-1:0]    dz_count
);

  vd_state_e           state_q;
  logic [RAM_SIZE-1:0] n_q, src_q, dst_q, i_q;
  logic [1:0]          mode_q;
  logic [NBITS-1:0]    x_q;

  logic [RAM_SIZE-1:0] i_inc, y_addr_cur, x_addr_next, dst_addr_cur;
  logic                div_start, div_signed, want_rem;
  logic [NBITS-1:0]    div_quo, div_rem, result;
  logic                div_done, div_dz;

  // Address arithmetic is carried in RAM_SIZE bits so it wraps silently.
  assign i_inc        = i_q + RAM_SIZE'(1);
  assign y_addr_cur   = src_q + (i_q << PAIR_STRIDE_LOG2) + RAM_SIZE'(Y_OFFSET);
  assign x_addr_next  = src_q + (i_inc << PAIR_STRIDE_LOG2) + RAM_SIZE'(X_OFFSET);
  assign dst_addr_cur = dst_q + i_q;

  assign div_signed = (mode_q == MODE_SQ) || (mode_q == MODE_SR);
  assign want_rem   = (mode_q == MODE_UR) || (mode_q == MODE_SR);
  assign result     = want_rem ? div_rem : div_quo;

  // Y is on Rdata during CAP_Y; the divider latches it directly on that edge.
  assign div_start = (state_q == ST_CAP_Y);

  div_core #(
    .NBITS(NBITS)
  ) u_div_core (
    .clock    (clock),
    .reset    (reset),
    .start    (div_start),
    .signed_en(div_signed),
    .dividend (x_q),
    .divisor  (Rdata),
    .quotient (div_quo),
    .remainder(div_rem),
    .done     (div_done),
    .dz       (div_dz)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      n_q      <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      i_q      <= '0;
      mode_q   <= MODE_UQ;
      x_q      <= '0;
      Addr     <= '0;
      Wdata    <= '0;
      Wenable  <= 1'b0;
      busyvd   <= 1'b0;
      donevd   <= 1'b0;
      dz_err   <= 1'b0;
      dz_count <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (startvd) begin
            n_q      <= Ndata;
            src_q    <= src_base;
            dst_q    <= dst_base;
            mode_q   <= mode;
            i_q      <= '0;
            dz_err   <= 1'b0;
            dz_count <= '0;
            busyvd   <= 1'b1;
            if (Ndata == '0) begin
              donevd  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              Addr    <= src_base + RAM_SIZE'(X_OFFSET);
              state_q <= ST_RD_X;
            end
          end
        end

        ST_RD_X: begin
          Addr    <= y_addr_cur;
          state_q <= ST_RD_Y;
        end

        ST_RD_Y: begin
          x_q     <= Rdata;
          state_q <= ST_CAP_Y;
        end

        ST_CAP_Y: begin
          state_q <= ST_DIV;
        end

        ST_DIV: begin
          if (div_done) begin
            Addr    <= dst_addr_cur;
            Wdata   <= result;
            Wenable <= 1'b1;
            state_q <= ST_WR;
            if (div_dz) begin
              dz_err <= 1'b1;
              if (dz_count != '1) begin
                dz_count <= dz_count + CNT_W'(1);
              end
            end
          end
        end

        ST_WR: begin
          Wenable <= 1'b0;
          i_q     <= i_inc;
          if (i_inc == n_q) begin
            donevd  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            Addr    <= x_addr_next;
            state_q <= ST_RD_X;
          end
        end

        ST_DONE: begin
          donevd  <= 1'b0;
          busyvd  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          Wenable <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_divider_mc.sv
// tb/tb_vector_divider_mc.sv - scoreboard bench for vector_divider_mc with a synchronous-read RAM model

module tb_vector_divider_mc;

  localparam int RS = 10;
  localparam int NB = 32;
  localparam int CW = 10;
  localparam logic [NB-1:0] MIN_V = 32'h8000_0000;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [RS-1:0] Addr;
  logic [NB-1:0] Wdata;
  logic [NB-1:0] Rdata;
  logic          Wenable;
  logic [RS-1:0] Ndata = '0, src_base = '0, dst_base = '0;
  logic [1:0]    mode = 2'b00;
  logic          startvd = 1'b0;
  logic          busyvd, donevd, dz_err;
  logic [CW-1:0] dz_count;

  logic [NB-1:0] mem [0:(1<<RS)-1];
  logic          tb_we = 1'b0;
  logic [RS-1:0] tb_addr = '0;
  logic [NB-1:0] tb_wd = '0;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [31:0] xs[$];
  logic [31:0] ys[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          we_count = 0;

  vector_divider_mc #(.RAM_SIZE(RS), .NBITS(NB), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .Addr(Addr), .Wdata(Wdata), .Rdata(Rdata),
    .Wenable(Wenable), .Ndata(Ndata), .src_base(src_base), .dst_base(dst_base),
    .mode(mode), .startvd(startvd), .busyvd(busyvd), .donevd(donevd),
    .dz_err(dz_err), .dz_count(dz_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    Rdata <= mem[Addr];
    if (Wenable) mem[Addr] <= Wdata;
    else if (tb_we) mem[tb_addr] <= tb_wd;
  end

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (Wenable === 1'b1) begin
      we_count++;
      expect_eq("wr_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        expect_eq("wr_addr", 64'(Addr), 64'(mon_e.addr));
        expect_eq("wr_data", 64'(Wdata), 64'(mon_e.data));
      end
    end
  end

  function automatic logic [31:0] model(input logic [1:0] md, input logic [31:0] x, input logic [31:0] y);
    logic signed [31:0] sx, sy;
    sx = x;
    sy = y;
    if (y == 32'd0) return md[0] ? x : 32'hFFFF_FFFF;
    if (md[1]) begin
      if (x == MIN_V && y == 32'hFFFF_FFFF) return md[0] ? 32'd0 : MIN_V;
      return md[0] ? 32'(sx % sy) : 32'(sx / sy);
    end
    return md[0] ? x % y : x / y;
  endfunction

  function automatic int elem_lat(input logic [1:0] md, input logic [31:0] x, input logic [31:0] y);
    if (y == 32'd0) return 5;
    if (md[1] && x == MIN_V && y == 32'hFFFF_FFFF) return 5;
    return 3 + NB + 1;
  endfunction

  task automatic poke(input int a, input logic [31:0] d);
    @(negedge clock);
    tb_we   = 1'b1;
    tb_addr = RS'(a);
    tb_wd   = d;
    @(negedge clock);
    tb_we   = 1'b0;
  endtask

  task automatic run_vec(input int n, input int src, input int dst, input logic [1:0] md, input bit hold);
    int exp_lat = 1;
    int exp_dz = 0;
    int cycles = 0;
    bit got = 0;
    int we0;
    for (int k = 0; k < n; k++) begin
      poke((src + 2*k) % 1024, xs[k]);
      poke((src + 2*k + 1) % 1024, ys[k]);
    end
    for (int k = 0; k < n; k++) begin
      exp_q.push_back('{(dst + k) % 1024, model(md, xs[k], ys[k])});
      exp_lat += elem_lat(md, xs[k], ys[k]);
      if (ys[k] == 32'd0) exp_dz++;
    end
    we0 = we_count;
    @(negedge clock);
    Ndata = RS'(n); src_base = RS'(src); dst_base = RS'(dst); mode = md;
    startvd = 1'b1;
    while (!got && cycles < 5000) begin
      @(negedge clock);
      if (!hold) startvd = 1'b0;
      cycles++;
      if (cycles == 1) expect_eq("busy_first", 64'(busyvd), 64'd1);
      if (donevd) got = 1;
    end
    startvd = 1'b0;
    expect_eq("done_seen", 64'(got), 64'd1);
    expect_eq("done_latency", 64'(cycles), 64'(exp_lat));
    expect_eq("dz_err", 64'(dz_err), 64'(exp_dz != 0));
    expect_eq("dz_count", 64'(dz_count), 64'(exp_dz));
    @(negedge clock);
    expect_eq("done_pulse_end", 64'(donevd), 64'd0);
    expect_eq("busy_end", 64'(busyvd), 64'd0);
    expect_eq("we_pulses", 64'(we_count - we0), 64'(n));
    expect_eq("sb_empty", 64'(exp_q.size()), 64'd0);
    for (int k = 0; k < n; k++)
      expect_eq("ram_result", 64'(mem[(dst + k) % 1024]), 64'(model(md, xs[k], ys[k])));
  endtask

  initial begin
    int cyc;
    repeat (3) @(negedge clock);
    expect_eq("rst_addr", 64'(Addr), 64'd0);
    expect_eq("rst_wdata", 64'(Wdata), 64'd0);
    expect_eq("rst_wen", 64'(Wenable), 64'd0);
    expect_eq("rst_busy", 64'(busyvd), 64'd0);
    expect_eq("rst_done", 64'(donevd), 64'd0);
    expect_eq("rst_dz_err", 64'(dz_err), 64'd0);
    expect_eq("rst_dz_count", 64'(dz_count), 64'd0);
    reset = 1'b0;

    // Unsigned quotient, three normal elements.
    xs = '{32'd100, 32'hFFFF_FFFF, 32'd5};
    ys = '{32'd7, 32'd2, 32'd9};
    run_vec(3, 0, 100, 2'b00, 0);

    // Signed remainder including MIN / -1.
    xs = '{32'hFFFF_FFF9, 32'd7, MIN_V};
    ys = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    run_vec(3, 200, 300, 2'b11, 0);

    // Signed quotient and unsigned remainder.
    xs = '{32'hFFFF_FFF9, MIN_V, 32'd100};
    ys = '{32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
    run_vec(3, 200, 310, 2'b10, 0);
    xs = '{32'd100, 32'd12345};
    ys = '{32'd7, 32'd100};
    run_vec(2, 200, 320, 2'b01, 0);

    // Divide by zero, unsigned quotient and signed remainder.
    xs = '{32'd42, 32'd9};
    ys = '{32'd0, 32'd3};
    run_vec(2, 400, 420, 2'b00, 0);
    xs = '{32'hFFFF_FFF0, 32'd11};
    ys = '{32'd0, 32'd0};
    run_vec(2, 400, 430, 2'b11, 0);

    // Address wrap on both source and destination.
    xs = '{32'd50, 32'd81};
    ys = '{32'd5, 32'd9};
    run_vec(2, 1022, 1023, 2'b00, 0);

    // Empty vector, then a run with startvd held high throughout.
    run_vec(0, 0, 0, 2'b00, 0);
    xs = '{32'd20};
    ys = '{32'd4};
    run_vec(1, 600, 610, 2'b00, 1);

    // Reset while element 1 is dividing.
    poke(700, 32'd42);
    poke(701, 32'd0);
    poke(702, 32'd9);
    poke(703, 32'd3);
    poke(721, 32'hDEAD);
    exp_q.push_back('{720, 32'hFFFF_FFFF});
    @(negedge clock);
    Ndata = RS'(2); src_base = RS'(700); dst_base = RS'(720); mode = 2'b00;
    startvd = 1'b1;
    cyc = 0;
    while (cyc < 14) begin
      @(negedge clock);
      startvd = 1'b0;
      cyc++;
    end
    expect_eq("dz_before_reset", 64'(dz_count), 64'd1);
    expect_eq("elem0_written", 64'(exp_q.size()), 64'd0);
    reset = 1'b1;
    @(negedge clock);
    expect_eq("abort_busy", 64'(busyvd), 64'd0);
    expect_eq("abort_wen", 64'(Wenable), 64'd0);
    expect_eq("abort_dz_count", 64'(dz_count), 64'd0);
    expect_eq("abort_dz_err", 64'(dz_err), 64'd0);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    expect_eq("abort_no_write", 64'(mem[721]), 64'hDEAD);
    xs = '{32'd1000, 32'd3};
    ys = '{32'd10, 32'd0};
    run_vec(2, 740, 760, 2'b00, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_divider_mc.md
Name: vector_divider_mc

Overview:
- Second-generation RAM-resident vector divider. Reads N operand pairs (X, Y) from a single-port RAM and computes quotient or remainder per pair, signed or unsigned. Writes one result per pair back to the RAM.
- Sits beside the I/O port block: started via startvd, reports busyvd/donevd.
- New over the previous generation:
  - programmable source/destination base addresses;
  - four arithmetic modes;
  - divide-by-zero and overflow handling with status;
  - NBITS-generic iterative divider.

Parameters:
- RAM_SIZE, 10, RAM address width (depth 2^RAM_SIZE words)
- NBITS, 32, data word width; divider iterations per element
- CNT_W, 10, width of dz_count

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- Addr  out  RAM_SIZE  RAM address
- Wdata  out  NBITS  RAM write data
- Rdata  in  NBITS  RAM read data, valid one cycle after Addr (synchronous read)
- Wenable  out  1  RAM write strobe
- Ndata  in  RAM_SIZE  number of pairs; sampled at start
- src_base  in  RAM_SIZE  operand base; sampled at start
- dst_base  in  RAM_SIZE  result base; sampled at start
- mode  in  2  00 unsigned quotient, 01 unsigned remainder, 10 signed quotient, 11 signed remainder; sampled at start
- startvd  in  1  start request, level or pulse
- busyvd  out  1  high from the cycle after accepted start until DONE exits
- donevd  out  1  one-cycle pulse at end of vector
- dz_err  out  1  sticky divide-by-zero flag; cleared on accepted start
- dz_count  out  CNT_W  number of zero divisors in current/last run; saturates

Behaviour:
- Reset values: Addr=0, Wdata=0, Wenable=0, busyvd=0, donevd=0, dz_err=0, dz_count=0; FSM in IDLE.
- Reset mid-operation aborts the run. Wenable is 0 from the next edge. No partial state is retained.
- Memory layout:
  - X(i) at src_base+2i; Y(i) at src_base+2i+1.
  - Result(i) at dst_base+i.
  - All address arithmetic is modulo 2^RAM_SIZE (wraps silently).
- FSM states: IDLE, RD_X, RD_Y, CAP_Y, DIV, WR, DONE.
  - IDLE: startvd=1 latches Ndata/src_base/dst_base/mode, clears dz_err/dz_count and i=0. Goes to DONE if Ndata==0, else RD_X. startvd is ignored outside IDLE.
  - RD_X: Addr=src_base+2i.
  - RD_Y: Addr=src_base+2i+1; capture X from Rdata.
  - CAP_Y: capture Y from Rdata; pulse div start.
  - DIV: wait for div_core done.
  - WR: Addr=dst_base+i, Wdata=result, Wenable=1 for exactly this cycle; i++. Go to DONE if i+1==Ndata, else RD_X.
  - DONE: donevd=1 for one cycle; busyvd drops the same edge; then IDLE.
- Latency:
  - Normal element: 3 + NBITS + 1 cycles (RD_X, RD_Y, CAP_Y, NBITS DIV cycles, WR).
  - Zero-divisor and signed-overflow elements: DIV takes 1 cycle.
  - Total from start to donevd = sum of element latencies + 1.
- Arithmetic:
  - Restoring division on magnitudes, one quotient bit per cycle.
  - Signed modes use truncation toward zero: quotient sign = sign(X) xor sign(Y); remainder sign = sign(X).
  - Y==0: quotient = all ones, remainder = X. Sets dz_err; dz_count++ (saturating at 2^CNT_W-1).
  - Signed X=MIN, Y=-1: quotient = MIN, remainder = 0. No flag.
- Wenable is never asserted outside WR. Addr holds its last value in IDLE/DONE.

Decomposition:
- Package vd_pkg:
  - FSM state encoding (localparam enum);
  - mode codes MODE_UQ, MODE_UR, MODE_SQ, MODE_SR;
  - address helper constants.
- Sub-module div_core:
  - ports: clock, reset, start, signed_en, dividend, divisor, quotient, remainder, done, dz;
  - NBITS-parametrised, iterative, with special-case short-circuit.
- Top level holds the FSM, index counter, address generation and status.

Test Plan:
- Unsigned quotient, NBITS=32, src_base=0, dst_base=100, Ndata=3, pairs (100,7), (0xFFFFFFFF,2), (5,9) -> RAM[100..102] = 14, 0x7FFFFFFF, 0; donevd one pulse at cycle 3*36+1 after start; exactly 3 Wenable pulses.
- Signed remainder mode 11, pairs (-7,2), (7,-2), (MIN,-1) -> results -1, 1, 0; dz_err=0.
- Divide-by-zero, mode 00, pairs (42,0), (9,3) -> results 0xFFFFFFFF, 3; dz_err=1, dz_count=1; first element takes 5 cycles.
- Wrap: RAM_SIZE=10, src_base=1022, dst_base=1023, Ndata=2 -> reads 1022, 1023, 0, 1; writes 1023 then 0.
- Ndata=0 -> no Wenable; busyvd high 1 cycle; donevd pulses. startvd held high during a run -> no restart until IDLE.
- Reset asserted in DIV of element 1 -> next cycle busyvd=0, Wenable=0, dz_count=0; new start runs cleanly from i=0.
